down_counter_3_bit: RTL
=======================

Name: down_counter_3_bit

Overview:
- Loadable down counter, default 3 bits; the decrementing counterpart to the team's 3-bit up counter.
- Drives timeout and delay sequencing in the sequential-circuits library.
- Supports parallel load, count enable, free-running wrap or one-shot (stop at zero) operation, and terminal-count/done status.
- A small control FSM (IDLE, COUNT, HOLD) sequences start, count and stop.

Parameters:
W, 3, counter width in bits (W >= 2)
RESET_VAL, 7, value of Y after reset (must fit in W bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
load  input  1  parallel load strobe; Y <= d on next edge
d  input  W  parallel load value
start  input  1  begin counting (IDLE or HOLD -> COUNT)
en  input  1  count enable; decrement only when high in COUNT
one_shot  input  1  1 = stop at zero (HOLD); 0 = wrap to 2^W-1
Y  output  W  counter value (registered)
tc  output  1  terminal count, combinational: Y == 0
done  output  1  registered one-cycle pulse on COUNT -> HOLD
busy  output  1  registered; 1 while state == COUNT

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- All state changes on the rising edge of clk. rst has priority over every other input.
- Reset values:
  - Y = RESET_VAL; state = IDLE; done = 0; busy = 0.
  - tc follows Y (0 unless RESET_VAL == 0).
- Input priority in every state: rst > load > start > en.
- IDLE:
  - Y holds.
  - load: Y <= d, stay IDLE.
  - start (no load): -> COUNT; Y unchanged; the first decrement occurs on a later edge.
  - en ignored.
- COUNT:
  - load: Y <= d, stay COUNT (mid-count reload); no decrement that cycle.
  - en=0: Y holds.
  - en=1, Y != 0: Y <= Y-1.
  - en=1, Y == 0, one_shot=0: Y <= 2^W-1 (wrap), stay COUNT.
  - en=1, Y == 0, one_shot=1: Y stays 0, -> HOLD, done=1 for exactly that next cycle.
  - one_shot is sampled only on the zero-crossing edge; it may change mid-count.
  - start ignored.
- HOLD:
  - Y holds 0.
  - load: Y <= d, -> IDLE.
  - start (no load): Y <= 2^W-1, -> COUNT.
  - en ignored.
- Outputs:
  - done is 0 in all cycles except the first cycle in HOLD.
  - busy = 1 from the cycle after entering COUNT through the cycle before leaving it.
- Boundaries:
  - load of 0 in COUNT with one_shot=1: the next enabled edge enters HOLD.
  - load and start together in IDLE: load wins, state stays IDLE.
  - rst mid-count: Y = RESET_VAL and IDLE on the next edge; done is not asserted.
  - Arithmetic is modulo 2^W. There are no X/undefined states; any unreachable state encoding returns to IDLE.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then en=1 for 3 cycles in IDLE -> Y=7, busy=0, tc=0 throughout.
- Wrap mode: start pulse, then en=1, one_shot=0, 9 edges -> Y sequence 7,6,5,4,3,2,1,0,7; tc=1 only while Y=0; done never asserts.
- One-shot: load d=3, start, en=1, one_shot=1 -> Y 3,2,1,0, then HOLD with Y=0; done=1 for exactly one cycle; busy drops the same cycle; further en has no effect.
- Enable gating and mid-count reload: in COUNT at Y=5, en=0 for 3 cycles -> Y stays 5; then load d=2 with en=1 -> Y=2, then 1 on the next edge.
- Restart from HOLD: after one-shot finish, start -> Y=7 and COUNT; alternatively load d=4 -> Y=4, IDLE, busy=0.
- Priority and reset: load d=1 and start in the same IDLE cycle -> Y=1, state IDLE. rst asserted at Y=4 in COUNT -> next cycle Y=7, busy=0, done=0.

Source files
------------

// File: rtl/down_counter_3_bit.sv
// Loadable W-bit down counter with wrap or one-shot (stop at zero) modes.
// A small IDLE/COUNT/HOLD controller sequences start, count and stop; tc, done and busy report status.
module down_counter_3_bit #(
   parameter int W         = 3,
   parameter int RESET_VAL = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         start,
   input  logic         en,
   input  logic         one_shot,
   output logic [W-1:0] Y,
   output logic         tc,
   output logic         done,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [W-1:0] ALL_ONES = '1;
   localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] y_nxt;

   // Modulo-2^W decrement.
   function automatic logic [W-1:0] dec_mod(input logic [W-1:0] v);
      return v - ONE;
   endfunction

   assign tc = (Y == '0);

   always_comb begin
      state_nxt = state;
      y_nxt     = Y;
      case (state)
         IDLE: begin
            if (load)
               y_nxt = d;
            else if (start)
               state_nxt = COUNT;
         end
         COUNT: begin
            if (load)
               y_nxt = d;
            else if (en) begin
               if (Y != '0)
                  y_nxt = dec_mod(Y);
               else if (!one_shot)
                  y_nxt = ALL_ONES;
               else
                  state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (load) begin
               y_nxt     = d;
               state_nxt = IDLE;
            end else if (start) begin
               y_nxt     = ALL_ONES;
               state_nxt = COUNT;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // busy and done are registered from the next-state decision so they line up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         Y     <= RESET_VAL[W-1:0];
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         Y     <= y_nxt;
         done  <= (state == COUNT) && (state_nxt == HOLD);
         busy  <= (state_nxt == COUNT);
      end
   end

endmodule
